// File: rtl/router_pkg.sv
// Shared constants and header-field helpers for the parametrised router datapath.
package router_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_ADDR_W   = 2;
  localparam int unsigned DEF_NUM_DEST = 3;

  localparam int unsigned CHK_XOR = 0;
  localparam int unsigned CHK_SUM = 1;

  // Helpers work on a wide container so they serve any DATA_W up to MAX_W
  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] hdr_addr(input logic [MAX_W-1:0] word,
                                                input int unsigned      addr_w);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << addr_w) - MAX_W'(1);
    return word & mask;
  endfunction

  function automatic logic [MAX_W-1:0] hdr_len(input logic [MAX_W-1:0] word,
                                               input int unsigned      addr_w);
    return word >> addr_w;
  endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Running integrity accumulator (XOR or modular sum) with a saturating payload counter.
module router_chk_acc
  import router_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned CHK_MODE = CHK_XOR
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              add_hdr,
  input  logic              add_data,
  input  logic [DATA_W-1:0] header,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] chk,
  output logic [DATA_W-1:0] count
);

  logic [DATA_W-1:0] chk_nxt_c;

  function automatic logic [DATA_W-1:0] chk_op(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    if (CHK_MODE == CHK_SUM) return a + b;
    return a ^ b;
  endfunction

  // Header and data terms chain so a (nominally illegal) overlap still folds in both
  always_comb begin
    chk_nxt_c = chk;
    if (add_hdr)  chk_nxt_c = chk_op(chk_nxt_c, header);
    if (add_data) chk_nxt_c = chk_op(chk_nxt_c, data_in);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chk   <= '0;
      count <= '0;
    end else if (clr) begin
      chk   <= '0;
      count <= '0;
    end else begin
      chk <= chk_nxt_c;
      if (add_data && (count != '1)) count <= count + DATA_W'(1);
    end
  end

endmodule

// File: rtl/router_reg_gen.sv
// Router datapath register stage: header latch, FIFO-full holding, integrity and length checks.
module router_reg_gen
  import router_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned NUM_DEST  = DEF_NUM_DEST,
  parameter int unsigned CHK_MODE  = CHK_XOR,
  parameter int unsigned LEN_CHECK = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err
);

  logic [DATA_W-1:0] header_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] chkbyte;
  logic [DATA_W-1:0] chk;
  logic [DATA_W-1:0] count;
  logic              addr_ok_c;
  logic              len_mismatch_c;
  logic              pd_set_c;

  assign addr_ok_c      = hdr_addr(MAX_W'(data_in), ADDR_W) < MAX_W'(NUM_DEST);
  assign len_mismatch_c = MAX_W'(count) != hdr_len(MAX_W'(header_reg), ADDR_W);
  assign pd_set_c       = (ld_state && !fifo_full && !pkt_valid) ||
                          (laf_state && low_pkt_valid && !parity_done);

  router_chk_acc #(
    .DATA_W   (DATA_W),
    .CHK_MODE (CHK_MODE)
  ) u_chk_acc (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (detect_add),
    .add_hdr  (lfd_state),
    .add_data (ld_state && pkt_valid && !full_state),
    .header   (header_reg),
    .data_in  (data_in),
    .chk      (chk),
    .count    (count)
  );

  // Header latch and output word path; full FIFO parks the word in hold_reg
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_reg <= '0;
      hold_reg   <= '0;
      chkbyte    <= '0;
      dout       <= '0;
    end else begin
      if (detect_add && pkt_valid && addr_ok_c) header_reg <= data_in;
      if (ld_state && !pkt_valid) chkbyte <= data_in;
      if (lfd_state)                    dout     <= header_reg;
      else if (ld_state && !fifo_full)  dout     <= data_in;
      else if (ld_state)                hold_reg <= data_in;
      else if (laf_state)               dout     <= hold_reg;
    end
  end

  // Packet status and error flags
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
      parity_done   <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      if (rst_int_reg)                low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid) low_pkt_valid <= 1'b1;

      if (detect_add)    parity_done <= 1'b0;
      else if (pd_set_c) parity_done <= 1'b1;

      if (detect_add) begin
        err     <= 1'b0;
        len_err <= 1'b0;
      end else if (parity_done) begin
        err     <= (chk != chkbyte);
        len_err <= (LEN_CHECK != 0) && len_mismatch_c;
      end
    end
  end

endmodule

// File: tb/tb_router_reg_gen.sv
// Scoreboard bench: XOR/length-checked instance and sum/no-length instance share one stimulus.
module tb_router_reg_gen;
  import router_pkg::*;

  typedef struct {
    logic err_x;
    logic len_x;
    logic err_s;
    logic len_s;
  } res_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg;
  logic [7:0] data_in;
  logic [7:0] dout_x, dout_s;
  logic       pd_x, pd_s, lpv_x, lpv_s, err_x, err_s, len_x, len_s;

  logic [7:0] dout_q[$];
  res_t       res_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clock = ~clock;

  router_reg_gen #(.DATA_W(8), .ADDR_W(2), .NUM_DEST(3), .CHK_MODE(CHK_XOR), .LEN_CHECK(1)) u_xor (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout_x), .parity_done(pd_x), .low_pkt_valid(lpv_x),
    .err(err_x), .len_err(len_x));

  router_reg_gen #(.DATA_W(8), .ADDR_W(2), .NUM_DEST(3), .CHK_MODE(CHK_SUM), .LEN_CHECK(0)) u_sum (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout_s), .parity_done(pd_s), .low_pkt_valid(lpv_s),
    .err(err_s), .len_err(len_s));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any cycle that writes dout pops the next expected word
  logic mon_w;
  always @(posedge clock) begin
    mon_w = resetn && (lfd_state || (ld_state && !fifo_full) || laf_state);
    #1;
    if (mon_w) begin
      if (dout_q.size() == 0) begin
        check("dout_unexpected_write", 32'(dout_x), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = dout_q.pop_front();
        check("dout_xor", 32'(dout_x), 32'(e));
        check("dout_sum", 32'(dout_s), 32'(e));
      end
    end
  end

  // Monitor: one cycle after parity_done rises the error flags are final
  logic pd_prev = 1'b0;
  logic res_done = 1'b0;
  always @(negedge clock) begin
    if (pd_x && pd_prev && !res_done) begin
      res_done = 1'b1;
      if (res_q.size() == 0) begin
        check("result_unexpected", 32'(pd_x), 32'(0));
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("err_xor",     32'(err_x), 32'(r.err_x));
        check("len_err_xor", 32'(len_x), 32'(r.len_x));
        check("err_sum",     32'(err_s), 32'(r.err_s));
        check("len_err_sum", 32'(len_s), 32'(r.len_s));
        check("pd_sum",      32'(pd_s),  32'(1));
        check("lpv_xor",     32'(lpv_x), 32'(1));
        check("lpv_sum",     32'(lpv_s), 32'(1));
      end
    end
    if (!pd_x) res_done = 1'b0;
    pd_prev = pd_x;
  end

  task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic fs, input logic ff, input logic pv, input logic rir,
                       input logic [7:0] d);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    full_state = fs; fifo_full = ff; pkt_valid = pv; rst_int_reg = rir; data_in = d;
    @(negedge clock);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pd"},      32'({pd_x, pd_s}),   32'(0));
    check({tag, "_err"},     32'({err_x, err_s}), 32'(0));
    check({tag, "_len_err"}, 32'({len_x, len_s}), 32'(0));
  endtask

  // Normal packet: header, lfd, n payload bytes, check byte, two idle cycles
  task automatic send_pkt(input logic [7:0] hdr, input int n,
                          input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                          input logic [7:0] cb, input logic ex, input logic lx,
                          input logic es, input logic ls);
    logic [7:0] pl[3];
    res_t r;
    pl[0] = p0; pl[1] = p1; pl[2] = p2;
    r.err_x = ex; r.len_x = lx; r.err_s = es; r.len_s = ls;
    dout_q.push_back(hdr);
    for (int i = 0; i < n; i++) dout_q.push_back(pl[i]);
    dout_q.push_back(cb);
    res_q.push_back(r);
    drive(1, 0, 0, 0, 0, 0, 1, 1, hdr);
    check_cleared("detect_clear");
    check("detect_clear_lpv", 32'({lpv_x, lpv_s}), 32'(0));
    drive(0, 1, 0, 0, 0, 0, 1, 0, p0);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 0, 0, 0, 1, 0, pl[i]);
    drive(0, 0, 1, 0, 0, 0, 0, 0, cb);
    idle();
    idle();
  endtask

  initial begin
    resetn = 1'b0;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; fifo_full = 0; pkt_valid = 0; rst_int_reg = 0; data_in = '0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    check("reset_dout", 32'({dout_x, dout_s}), 32'(0));
    check("reset_lpv",  32'({lpv_x, lpv_s}),   32'(0));
    check_cleared("reset");

    // Header 0D: addr 1, len 3. XOR of 0D,11,22,33 = 0D; sum = 73
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D, 0, 0, 1, 0);
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0C, 1, 0, 1, 0);
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h73, 1, 0, 0, 0);
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h74, 1, 0, 1, 0);
    // Short payload: XOR 3E, sum 40, count 2 vs len 3
    send_pkt(8'h0D, 2, 8'h11, 8'h22, 8'h00, 8'h3E, 0, 1, 1, 0);
    send_pkt(8'h0D, 2, 8'h11, 8'h22, 8'h00, 8'h40, 1, 1, 0, 0);
    // Zero-length: header 02 (addr 2, len 0), chk equals header in both modes
    send_pkt(8'h02, 0, 8'h00, 8'h00, 8'h00, 8'h02, 0, 0, 0, 0);

    // FIFO full mid-payload: 22 parked, then released through laf
    dout_q.push_back(8'h0D); dout_q.push_back(8'h11);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 8'h0D);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
    drive(0, 0, 1, 0, 0, 1, 1, 0, 8'h22);
    check("full_hold_dout", 32'({dout_x, dout_s}), 32'({8'h11, 8'h11}));
    drive(0, 0, 0, 0, 1, 1, 1, 0, 8'h22);
    dout_q.push_back(8'h22);
    drive(0, 0, 0, 1, 0, 0, 1, 0, 8'h22);
    check("laf_no_pd", 32'({pd_x, pd_s}), 32'(0));
    dout_q.push_back(8'h33); dout_q.push_back(8'h0D);
    res_q.push_back('{err_x: 0, len_x: 0, err_s: 1, len_s: 0});
    drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h33);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 8'h0D);
    idle(); idle();

    // Check byte arrives while full; laf with low_pkt_valid completes the packet
    dout_q.push_back(8'h0D); dout_q.push_back(8'h11);
    dout_q.push_back(8'h22); dout_q.push_back(8'h33);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 8'h0D);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
    drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h22);
    drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h33);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 8'h0D);
    check("full_cb_dout", 32'(dout_x), 32'(8'h33));
    check("full_cb_pd",   32'({pd_x, pd_s}),   32'(0));
    check("full_cb_lpv",  32'({lpv_x, lpv_s}), 32'({1'b1, 1'b1}));
    drive(0, 0, 0, 0, 1, 1, 0, 0, 8'h0D);
    dout_q.push_back(8'h0D);
    res_q.push_back('{err_x: 0, len_x: 0, err_s: 1, len_s: 0});
    drive(0, 0, 0, 1, 0, 0, 0, 0, 8'h0D);
    check("laf_sets_pd", 32'({pd_x, pd_s}), 32'({1'b1, 1'b1}));
    idle(); idle();

    // Invalid address 3 keeps the previous header 0D
    drive(1, 0, 0, 0, 0, 0, 1, 1, 8'h03);
    dout_q.push_back(8'h0D);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    idle();

    // Leave low_pkt_valid set, then reset asynchronously mid-payload
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D, 0, 0, 1, 0);
    dout_q.push_back(8'h0D); dout_q.push_back(8'h11);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h0D);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
    check("pre_reset_lpv", 32'({lpv_x, lpv_s}), 32'({1'b1, 1'b1}));
    #2 resetn = 1'b0;
    #1;
    check("async_rst_dout", 32'({dout_x, dout_s}), 32'(0));
    check("async_rst_lpv",  32'({lpv_x, lpv_s}),   32'(0));
    check_cleared("async_rst");
    detect_add = 0; lfd_state = 0; ld_state = 0; pkt_valid = 0;
    @(negedge clock);
    resetn = 1'b1;
    send_pkt(8'h02, 0, 8'h00, 8'h00, 8'h00, 8'h02, 0, 0, 0, 0);

    for (int i = 0; i < 20 && (dout_q.size() != 0 || res_q.size() != 0); i++) @(negedge clock);
    check("dout_q_drained", 32'(dout_q.size()), 32'(0));
    check("res_q_drained",  32'(res_q.size()),  32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_reg_gen.md
Name: router_reg_gen

Overview:
Parametrised datapath register stage for the router family, generalised from the fixed 8-bit 1x3 register block. It sits between the input packet stream and the destination FIFOs, under control of the router FSM. It latches the header, forwards payload to `dout`, and holds one byte while the FIFO is full. It also runs a selectable integrity check (XOR parity or modular sum) and a payload-length check against the length field carried in the header.

Parameters:
- DATA_W, 8, byte/word width of `data_in`/`dout`.
- ADDR_W, 2, header address field width, at `data_in[ADDR_W-1:0]`.
- NUM_DEST, 3, number of valid destinations; an address >= NUM_DEST is invalid.
- CHK_MODE, 0, check algorithm: 0 = XOR parity, 1 = sum mod 2^DATA_W.
- LEN_CHECK, 1, 1 enables the payload-length check; 0 forces `len_err` to 0.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  high during header and payload; low on the check byte.
- fifo_full  in  1  full flag of the selected destination FIFO.
- detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state decodes.
- rst_int_reg  in  1  FSM request to clear `low_pkt_valid`.
- data_in  in  DATA_W  packet stream.
- dout  out  DATA_W  word written to the FIFO.
- parity_done  out  1  check byte has been captured.
- low_pkt_valid  out  1  end of packet seen.
- err  out  1  check mismatch.
- len_err  out  1  payload count differs from the header length field.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on `resetn`. Every register clears to 0: `dout`, header register, hold register, running check, check byte, payload counter, `parity_done`, `low_pkt_valid`, `err`, `len_err`. Assertion mid-packet aborts the packet immediately.
- Header capture: on `detect_add & pkt_valid & (data_in[ADDR_W-1:0] < NUM_DEST)`, header_reg <= `data_in`.
  - An invalid address leaves header_reg unchanged.
  - The length field is `data_in[DATA_W-1:ADDR_W]`, which is DATA_W-ADDR_W bits wide.
- `dout` priority (first match wins):
  1. `lfd_state`: `dout` <= header_reg.
  2. `ld_state & !fifo_full`: `dout` <= `data_in`.
  3. `ld_state & fifo_full`: hold_reg <= `data_in`; `dout` holds.
  4. `laf_state`: `dout` <= hold_reg.
  5. Otherwise `dout` holds.
- Running check (chk): all arithmetic is DATA_W wide; carries are discarded.
  - On `detect_add`: chk <= 0 and count <= 0.
  - On `lfd_state`: chk <= chk OP header_reg, where OP is XOR if CHK_MODE=0, otherwise +.
  - On `ld_state & pkt_valid & !full_state`: chk <= chk OP `data_in`, and count <= count+1.
  - count saturates at its all-ones value and never wraps.
- Check byte: on `ld_state & !pkt_valid`, chkbyte <= `data_in`.
- `low_pkt_valid`:
  - `rst_int_reg` clears it, with the highest priority.
  - Otherwise it sets on `ld_state & !pkt_valid`.
  - Otherwise it holds.
- `parity_done`:
  - `detect_add` clears it.
  - It sets on `ld_state & !fifo_full & !pkt_valid`.
  - It also sets on `laf_state & low_pkt_valid & !parity_done`.
  - It holds until the next `detect_add`.
- Error evaluation, on any cycle where `parity_done`==1 (registered, so valid one cycle after `parity_done` rises):
  - `err` <= (chk != chkbyte).
  - `len_err` <= LEN_CHECK & (count != header_reg length field).
  - `detect_add` clears both; otherwise both hold.
- Simultaneous events:
  - `detect_add` together with `parity_done`: the clear wins.
  - `lfd_state` and `ld_state` are never asserted together by the FSM. If they are, `lfd_state` priority applies to `dout`, and both still update chk.
- Zero-length packet (header then check byte): count=0, chk=header, and `len_err`=0 when the length field is 0.

Decomposition:
- Shared package `router_pkg` holds:
  - the CHK_MODE encodings CHK_XOR=0 and CHK_SUM=1;
  - the helper functions `hdr_addr()` and `hdr_len()`;
  - the default DATA_W/ADDR_W/NUM_DEST constants.
- One natural sub-module is `router_chk_acc`: the chk/count accumulator with CHK_MODE and the saturating counter. The rest stays in the top.

Test Plan:
1. DATA_W=8, CHK_MODE=0. Header 8'h0D (addr 1, len 3), payload 11, 22, 33, check byte 0D.
   - Expected: `dout` sequence 0D, 11, 22, 33, 0D; `parity_done`=1; `low_pkt_valid`=1; next cycle `err`=0 and `len_err`=0.
2. Same packet, check byte 0C.
   - Expected: `err`=1, `len_err`=0. A following `detect_add` clears `err` and `parity_done`.
3. CHK_MODE=1, same packet with check byte 8'h73 (0D+11+22+33).
   - Expected: `err`=0. With check byte 8'h74: `err`=1.
4. Header 8'h0D, 2 payload bytes, then check byte.
   - Expected: `len_err`=1. With LEN_CHECK=0: `len_err`=0.
5. `ld_state` with `fifo_full`=1 and data 8'h22.
   - Expected: `dout` unchanged. Then `laf_state` gives `dout`=22. With `low_pkt_valid`=1, `laf_state` sets `parity_done`.
6. Header 8'h03 (addr 3 invalid) after a valid header 8'h0D.
   - Expected: `lfd_state` outputs 0D.
   - Reset during payload clears all outputs to 0 asynchronously.
